// File: rtl/quad_pwm_cfg_sched_if.sv
// rtl/quad_pwm_cfg_sched_if.sv - byte-serial command stream handshake bundle
interface quad_pwm_cfg_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/quad_pwm_cfg_sched.sv
// rtl/quad_pwm_cfg_sched.sv - shadowed 4-channel PWM config, committed on period wrap
module quad_pwm_cfg_sched #(
  parameter int TIMEOUT_CYC = 255,
  parameter int AUTO_COMMIT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  quad_pwm_cfg_sched_if.slave         cmd,
  input  logic                        pwm_wrap,
  output logic [31:0]                 duty_out,
  output logic [3:0]                  en_out,
  output logic                        commit_pending,
  output logic                        commit_done,
  output logic                        err
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TMO_MAX  = CW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_WAIT} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   tmo_cnt;
  logic [1:0]      ch;
  logic [3:0][7:0] shadow_duty;
  logic [3:0]      shadow_en;

  logic xfer, do_duty_hdr, do_mask, do_commit, do_revert, do_data, do_timeout, do_apply;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_HDR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    cmd.cmd_ready = (state != S_WAIT);
    xfer          = cmd.cmd_valid && (state != S_WAIT);
    do_duty_hdr   = 1'b0;
    do_mask       = 1'b0;
    do_commit     = 1'b0;
    do_revert     = 1'b0;
    do_data       = 1'b0;
    do_timeout    = 1'b0;
    do_apply      = 1'b0;
    case (state)
      S_HDR: begin
        if (xfer) begin
          case (cmd.cmd_data[7:6])
            2'b00: begin do_duty_hdr = 1'b1; state_nx = S_DATA; end
            2'b01: begin
              do_mask = 1'b1;
              if (AUTO_COMMIT != 0) state_nx = S_WAIT;
            end
            2'b10:   begin do_commit = 1'b1; state_nx = S_WAIT; end
            default: do_revert = 1'b1;
          endcase
        end
      end
      S_DATA: begin
        if (xfer) begin
          do_data  = 1'b1;
          state_nx = (AUTO_COMMIT != 0) ? S_WAIT : S_HDR;
        end else if (tmo_cnt >= TMO_LAST) begin
          // this idle edge is the TIMEOUT_CYC-th one since the header
          do_timeout = 1'b1;
          state_nx   = S_HDR;
        end
      end
      S_WAIT: begin
        // entered only after the commit edge, so a coincident wrap is never seen here
        if (pwm_wrap) begin
          do_apply = 1'b1;
          state_nx = S_HDR;
        end
      end
      default: state_nx = S_HDR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt        <= '0;
      ch             <= 2'd0;
      shadow_duty    <= '0;
      shadow_en      <= 4'd0;
      duty_out       <= 32'd0;
      en_out         <= 4'd0;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      err            <= 1'b0;
    end else begin
      commit_done <= do_apply;
      err         <= do_timeout;
      if (do_duty_hdr) begin
        tmo_cnt <= '0;
        ch      <= cmd.cmd_data[1:0];
      end else if (state == S_DATA && !xfer && tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (do_data)  shadow_duty[ch] <= cmd.cmd_data;
      if (do_mask)  shadow_en       <= cmd.cmd_data[3:0];
      if (do_revert) begin
        shadow_duty <= duty_out;
        shadow_en   <= en_out;
      end
      if (do_commit || ((AUTO_COMMIT != 0) && (do_data || do_mask)))
        commit_pending <= 1'b1;
      else if (do_apply)
        commit_pending <= 1'b0;
      if (do_apply) begin
        duty_out <= shadow_duty;
        en_out   <= shadow_en;
      end
    end
  end
endmodule

// File: tb/tb_quad_pwm_cfg_sched.sv
// tb/tb_quad_pwm_cfg_sched.sv - random + directed check of two configurations against a protocol model
module tb_quad_pwm_cfg_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wrap = 1'b0;
  always #5 clk = ~clk;

  quad_pwm_cfg_sched_if bus0 ();
  quad_pwm_cfg_sched_if bus1 ();

  logic [31:0] duty_o [2];
  logic [3:0]  en_o   [2];
  logic        pend_o [2];
  logic        done_o [2];
  logic        err_o  [2];

  quad_pwm_cfg_sched #(.TIMEOUT_CYC(255), .AUTO_COMMIT(0)) dut0 (
    .clk(clk), .rst(rst), .cmd(bus0), .pwm_wrap(wrap),
    .duty_out(duty_o[0]), .en_out(en_o[0]), .commit_pending(pend_o[0]),
    .commit_done(done_o[0]), .err(err_o[0]));

  quad_pwm_cfg_sched #(.TIMEOUT_CYC(4), .AUTO_COMMIT(1)) dut1 (
    .clk(clk), .rst(rst), .cmd(bus1), .pwm_wrap(wrap),
    .duty_out(duty_o[1]), .en_out(en_o[1]), .commit_pending(pend_o[1]),
    .commit_done(done_o[1]), .err(err_o[1]));

  int checks = 0;
  int errors = 0;

  // reference: phase 0 = expecting header, 1 = expecting data, 2 = waiting for wrap
  int         m_tmo  [2] = '{255, 4};
  bit         m_auto [2] = '{1'b0, 1'b1};
  logic [7:0] m_sh   [2][4];
  logic [7:0] m_act  [2][4];
  logic [3:0] m_shen [2];
  logic [3:0] m_acten[2];
  int         m_phase[2];
  int         m_ch   [2];
  int         m_idle [2];
  bit         m_pend [2];
  bit         m_done [2];
  bit         m_err  [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin m_sh[k][c] = 8'h00; m_act[k][c] = 8'h00; end
      m_shen[k] = 4'h0; m_acten[k] = 4'h0;
      m_phase[k] = 0; m_ch[k] = 0; m_idle[k] = 0;
      m_pend[k] = 1'b0; m_done[k] = 1'b0; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit v, input logic [7:0] d, input bit w);
    m_done[k] = 1'b0;
    m_err[k]  = 1'b0;
    if (m_phase[k] == 0) begin
      if (v) begin
        if (d[7:6] == 2'b00) begin
          m_ch[k] = int'(d[1:0]); m_idle[k] = 0; m_phase[k] = 1;
        end else if (d[7:6] == 2'b01) begin
          m_shen[k] = d[3:0];
          if (m_auto[k]) begin m_pend[k] = 1'b1; m_phase[k] = 2; end
        end else if (d[7:6] == 2'b10) begin
          m_pend[k] = 1'b1; m_phase[k] = 2;
        end else begin
          for (int c = 0; c < 4; c++) m_sh[k][c] = m_act[k][c];
          m_shen[k] = m_acten[k];
        end
      end
    end else if (m_phase[k] == 1) begin
      if (v) begin
        m_sh[k][m_ch[k]] = d;
        if (m_auto[k]) begin m_pend[k] = 1'b1; m_phase[k] = 2; end
        else m_phase[k] = 0;
      end else begin
        m_idle[k]++;
        if (m_idle[k] >= m_tmo[k]) begin m_err[k] = 1'b1; m_phase[k] = 0; end
      end
    end else if (w) begin
      for (int c = 0; c < 4; c++) m_act[k][c] = m_sh[k][c];
      m_acten[k] = m_shen[k];
      m_done[k] = 1'b1; m_pend[k] = 1'b0; m_phase[k] = 0;
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("duty%0d", k), 64'(duty_o[k]),
          64'({m_act[k][3], m_act[k][2], m_act[k][1], m_act[k][0]}));
      chk($sformatf("en%0d", k),      64'(en_o[k]),   64'(m_acten[k]));
      chk($sformatf("pending%0d", k), 64'(pend_o[k]), 64'(m_pend[k]));
      chk($sformatf("done%0d", k),    64'(done_o[k]), 64'(m_done[k]));
      chk($sformatf("err%0d", k),     64'(err_o[k]),  64'(m_err[k]));
    end
    chk("ready0", 64'(bus0.cmd_ready), 64'(m_phase[0] != 2));
    chk("ready1", 64'(bus1.cmd_ready), 64'(m_phase[1] != 2));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit w);
    bus0.cmd_valid = v; bus0.cmd_data = d;
    bus1.cmd_valid = v; bus1.cmd_data = d;
    wrap = w;
    @(posedge clk);
    model_step(0, v, d, w);
    model_step(1, v, d, w);
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    bus0.cmd_valid = 1'b0; bus0.cmd_data = 8'h00;
    bus1.cmd_valid = 1'b0; bus1.cmd_data = 8'h00;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // duty write to ch2 then commit, wrap some cycles later
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0);
    chk("t1_before_wrap", 64'(duty_o[0]), 64'h0);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_duty_ch2", 64'(duty_o[0]), 64'h0080_0000);
    chk("t1_done", 64'(done_o[0]), 64'h1);
    step(1'b0, 8'h00, 1'b0);
    chk("t1_done_once", 64'(done_o[0]), 64'h0);

    // wrap coincident with the commit header is ignored
    step(1'b1, 8'h4A, 1'b0);
    step(1'b1, 8'h80, 1'b1);
    chk("t2_no_early_en", 64'(en_o[0]), 64'h0);
    chk("t2_ready_low", 64'(bus0.cmd_ready), 64'h0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t2_en", 64'(en_o[0]), 64'hA);
    chk("t2_pending_fall", 64'(pend_o[0]), 64'h0);

    // header then silence until the abort
    step(1'b1, 8'h01, 1'b0);
    repeat (254) step(1'b0, 8'h00, 1'b0);
    chk("t3_no_err_yet", 64'(err_o[0]), 64'h0);
    step(1'b0, 8'h00, 1'b0);
    chk("t3_err", 64'(err_o[0]), 64'h1);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t3_ch0_ch1", 64'(duty_o[0][15:0]), 64'h0033);

    // revert discards the pending shadow write
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hC0, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_duty_kept", 64'(duty_o[0]), 64'h0080_0033);

    // reset while a commit is pending
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    chk("t5_pending", 64'(pend_o[0]), 64'h1);
    apply_reset();
    chk("t5_duty_zero", 64'(duty_o[0]), 64'h0);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_no_done", 64'(done_o[0]), 64'h0);

    // auto-commit instance: a data byte alone requests the commit
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h10, 1'b0);
    chk("t6_pending", 64'(pend_o[1]), 64'h1);
    chk("t6_ready_low", 64'(bus1.cmd_ready), 64'h0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("t6_ch1", 64'(duty_o[1]), 64'h0000_1000);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) apply_reset();
      if ($urandom_range(0, 49) == 0) repeat (6) step(1'b0, 8'h00, 1'b0);
      d = 8'($urandom);
      case ($urandom_range(0, 7))
        0, 1:    d[7:6] = 2'b00;
        2:       d[7:6] = 2'b01;
        3:       d[7:6] = 2'b10;
        4:       d[7:6] = 2'b11;
        default: ;
      endcase
      step($urandom_range(0, 2) != 0, d, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_pwm_cfg_sched.md
Name: quad_pwm_cfg_sched

Overview:
- Configuration sequencer for the quad PWM datapath.
- Accepts a byte-serial command stream over a valid/ready handshake and holds shadow duty and enable registers for 4 channels.
- Commits shadows to the active registers driving the PWM comparators only at a PWM period boundary (pwm_wrap), so a period never mixes old and new settings.
- Sits between the ui_in/uio command decode and the 4-channel PWM counter/compare block.

Parameters:
- TIMEOUT_CYC, 255: max idle cycles between header and data byte before abort; must be ≥1.
- AUTO_COMMIT, 0: if 1, every accepted duty or mask write also requests a commit.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous and active-high.
- cmd_valid  input  1  command byte valid.
- cmd_ready  output  1  block can accept a byte.
- cmd_data  input  8  command byte.
- pwm_wrap  input  1  1-cycle pulse from PWM counter at period end (count == max).
- duty_out  output  32  active duties; ch n = [8n+7:8n].
- en_out  output  4  active channel enable mask.
- commit_pending  output  1  commit requested, waiting for pwm_wrap.
- commit_done  output  1  1-cycle pulse on the cycle active registers update.
- err  output  1  1-cycle pulse on timeout abort.

Behaviour:
- Reset (async assert, sync-safe deassert): all state cleared.
  - duty_out=0, en_out=0, shadows=0.
  - commit_pending=0, commit_done=0, err=0.
  - FSM=S_HDR, so cmd_ready=1.
- Transfer: a byte transfers on a rising edge with cmd_valid&&cmd_ready.
  - cmd_ready is combinational from state: 1 in S_HDR and S_DATA, 0 in S_WAIT.
- Header decode, bits[7:6]:
  - 00 duty write: ch=bits[1:0], latched; go to S_DATA, clear timeout counter.
  - 01 mask write: shadow_en<=bits[3:0]; stay in S_HDR.
  - 10 commit: commit_pending<=1; go to S_WAIT.
  - 11 revert: shadow_duty/shadow_en <= active values; commit_pending unaffected; stay in S_HDR.
  - Unused header bits are ignored.
- S_DATA:
  - Accepted byte goes to shadow_duty[ch]; return to S_HDR.
  - Timeout counter increments each cycle without a transfer.
  - When the count reaches TIMEOUT_CYC: pulse err, discard the write, return to S_HDR. Shadows are unchanged.
- S_WAIT:
  - On the first pwm_wrap strictly after the cycle the commit header was accepted:
    - duty_out<=shadow_duty, en_out<=shadow_en.
    - commit_done pulse, commit_pending<=0, return to S_HDR.
  - A pwm_wrap coincident with the commit header's acceptance edge does not count; the block waits for the next wrap.
  - Latency from wrap to updated outputs is 1 clock (registered).
- AUTO_COMMIT=1:
  - A completed duty write (data byte) or a mask write sets commit_pending.
  - FSM goes to S_WAIT instead of S_HDR; commit then proceeds as above.
- pwm_wrap outside S_WAIT has no effect. Active registers change only via commit.
- Back-to-back bytes are allowed: a data byte may directly follow its header on the next cycle at full rate.
- Reset mid-operation: pending commit and partial command are lost; outputs go to 0 immediately (async).
- Timeout counter width is clog2(TIMEOUT_CYC+1). It saturates and does not wrap.

Test Plan:
- Reset, then send 0x02,0x80, commit 0x80; pulse pwm_wrap 5 cycles later -> duty_out[23:16]=0x80 exactly 1 clk after wrap; commit_done pulses once; other channels stay 0.
- Send 0x40|0xA (mask), 0x80 with pwm_wrap asserted the same cycle -> no update on that wrap; cmd_ready=0; next wrap sets en_out=4'hA, commit_pending falls.
- Send header 0x01, then hold cmd_valid=0 for TIMEOUT_CYC cycles -> err pulses once, FSM back to S_HDR; next 0x00,0x33,0x80 plus wrap sets only ch0=0x33; ch1 unchanged.
- Write ch3=0xFF, send revert 0xC0, commit, wrap -> duty_out unchanged (ch3 remains previous active value).
- Assert rst while commit_pending=1 -> all outputs 0 within the reset cycle, cmd_ready=1; a subsequent wrap causes no commit_done.
- AUTO_COMMIT=1: send 0x01,0x10 -> commit_pending=1, cmd_ready=0 until wrap; then ch1=0x10.
